// File: rtl/serv_vlsu_agu.sv
// rtl/serv_vlsu_agu.sv - vector load/store address generator driving a word-aligned data bus.
// Optional feature macro: SERV_VLSU_STRIDE_EN (strided addressing; unit-stride when undefined).
module serv_vlsu_agu #(
  parameter int VL_W = 6
) (
  input  logic            i_clk,
  input  logic            i_rst_n,
  input  logic            i_start,
  input  logic            i_we,
  input  logic [31:0]     i_base,
  input  logic [31:0]     i_stride,
  input  logic [VL_W-1:0] i_vl,
  input  logic [1:0]      i_sew,
  output logic [31:0]     o_dbus_adr,
  output logic [3:0]      o_dbus_sel,
  output logic            o_dbus_we,
  output logic            o_dbus_cyc,
  input  logic            i_dbus_ack,
  output logic [VL_W-1:0] o_elem_idx,
  output logic            o_busy,
  output logic            o_done,
  output logic            o_err
);

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_REQ  = 2'b01,
    S_DONE = 2'b10
  } state_e;

  localparam logic [VL_W-1:0] ONE = {{(VL_W-1){1'b0}}, 1'b1};

  state_e          state_q, state_d;
  logic [31:0]     addr_q, addr_d;
  logic [VL_W-1:0] idx_q, idx_d;
  logic [VL_W-1:0] vl_q, vl_d;
  logic [1:0]      sew_q, sew_d;
  logic            we_q, we_d;
  logic            err_q, err_d;
  logic [31:0]     incr;
  logic [31:0]     addr_next;
  logic            last_elem;

`ifdef SERV_VLSU_STRIDE_EN
  logic [31:0] stride_q, stride_d;
  assign incr = stride_q;
`else
  logic unused_stride;
  assign unused_stride = ^i_stride;
  assign incr = {29'b0, sew_q == 2'b10, sew_q == 2'b01, sew_q == 2'b00};
`endif

  function automatic logic misaligned(input logic [31:0] a, input logic [1:0] sew);
    case (sew)
      2'b01:   misaligned = a[0];
      2'b10:   misaligned = |a[1:0];
      default: misaligned = 1'b0;
    endcase
  endfunction

  assign addr_next = addr_q + incr;
  assign last_elem = (idx_q == (vl_q - ONE));

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    idx_d   = idx_q;
    vl_d    = vl_q;
    sew_d   = sew_q;
    we_d    = we_q;
    err_d   = err_q;
`ifdef SERV_VLSU_STRIDE_EN
    stride_d = stride_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (i_start) begin
          addr_d = i_base;
          idx_d  = '0;
          vl_d   = i_vl;
          sew_d  = i_sew;
          we_d   = i_we;
`ifdef SERV_VLSU_STRIDE_EN
          stride_d = i_stride;
`endif
          // The first element is vetted here so a bad request never raises cyc.
          if (i_sew == 2'b11) begin
            err_d   = 1'b1;
            state_d = S_DONE;
          end else if (i_vl == '0) begin
            err_d   = 1'b0;
            state_d = S_DONE;
          end else if (misaligned(i_base, i_sew)) begin
            err_d   = 1'b1;
            state_d = S_DONE;
          end else begin
            err_d   = 1'b0;
            state_d = S_REQ;
          end
        end
      end
      S_REQ: begin
        if (i_dbus_ack) begin
          addr_d = addr_next;
          idx_d  = idx_q + ONE;
          if (last_elem) begin
            state_d = S_DONE;
          end else if (misaligned(addr_next, sew_q)) begin
            err_d   = 1'b1;
            state_d = S_DONE;
          end
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= S_IDLE;
      addr_q  <= '0;
      idx_q   <= '0;
      vl_q    <= '0;
      sew_q   <= '0;
      we_q    <= 1'b0;
      err_q   <= 1'b0;
`ifdef SERV_VLSU_STRIDE_EN
      stride_q <= '0;
`endif
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      idx_q   <= idx_d;
      vl_q    <= vl_d;
      sew_q   <= sew_d;
      we_q    <= we_d;
      err_q   <= err_d;
`ifdef SERV_VLSU_STRIDE_EN
      stride_q <= stride_d;
`endif
    end
  end

  always_comb begin
    o_dbus_cyc = (state_q == S_REQ);
    o_dbus_adr = '0;
    o_dbus_sel = '0;
    o_dbus_we  = 1'b0;
    if (state_q == S_REQ) begin
      o_dbus_adr = {addr_q[31:2], 2'b00};
      o_dbus_we  = we_q;
      case (sew_q)
        2'b00:   o_dbus_sel = 4'b0001 << addr_q[1:0];
        2'b01:   o_dbus_sel = 4'b0011 << addr_q[1:0];
        default: o_dbus_sel = 4'b1111;
      endcase
    end
    o_elem_idx = idx_q;
    o_busy     = (state_q != S_IDLE);
    o_done     = (state_q == S_DONE);
    o_err      = (state_q == S_DONE) && err_q;
  end

endmodule

// File: tb/tb_serv_vlsu_agu.sv
// tb/tb_serv_vlsu_agu.sv - randomized self-checking bench for serv_vlsu_agu.
module tb_serv_vlsu_agu;

  localparam int VL_W = 6;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            start = 1'b0;
  logic            we = 1'b0;
  logic [31:0]     base = '0;
  logic [31:0]     stride = '0;
  logic [VL_W-1:0] vl = '0;
  logic [1:0]      sew = '0;
  logic [31:0]     dbus_adr;
  logic [3:0]      dbus_sel;
  logic            dbus_we;
  logic            dbus_cyc;
  logic            dbus_ack = 1'b0;
  logic [VL_W-1:0] elem_idx;
  logic            busy;
  logic            done;
  logic            err;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  serv_vlsu_agu #(.VL_W(VL_W)) dut (
    .i_clk      (clk),
    .i_rst_n    (rst_n),
    .i_start    (start),
    .i_we       (we),
    .i_base     (base),
    .i_stride   (stride),
    .i_vl       (vl),
    .i_sew      (sew),
    .o_dbus_adr (dbus_adr),
    .o_dbus_sel (dbus_sel),
    .o_dbus_we  (dbus_we),
    .o_dbus_cyc (dbus_cyc),
    .i_dbus_ack (dbus_ack),
    .o_elem_idx (elem_idx),
    .o_busy     (busy),
    .o_done     (done),
    .o_err      (err)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  logic [31:0] exp_adr[$];
  logic [3:0]  exp_sel[$];
  logic        exp_err;

  // Reference: walk element addresses base + i*inc, stop at the first one that is
  // not a multiple of the element size.
  task automatic build_model(input logic [31:0] b, input logic [31:0] s,
                             input int n, input int w);
    int unsigned size;
    logic [31:0] inc;
    logic [31:0] a;
    logic [3:0]  lanes;
    exp_adr.delete();
    exp_sel.delete();
    exp_err = 1'b0;
    if (w == 3) begin
      exp_err = 1'b1;
      return;
    end
    size = 1 << w;
`ifdef SERV_VLSU_STRIDE_EN
    inc = s;
`else
    inc = size;
`endif
    for (int i = 0; i < n; i++) begin
      a = b + inc * i;
      if ((a % size) != 0) begin
        exp_err = 1'b1;
        return;
      end
      lanes = (w == 2) ? 4'hF : 4'(((1 << size) - 1) << (a % 4));
      exp_adr.push_back(a & 32'hFFFF_FFFC);
      exp_sel.push_back(lanes);
    end
  endtask

  task automatic run_op(input logic w_e, input logic [31:0] b, input logic [31:0] s,
                        input int n, input int w, input int max_wait, input bit poke_start);
    int k;
    int wt;
    int d;
    int cycles;
    build_model(b, s, n, w);
    @(negedge clk);
    start = 1'b1; we = w_e; base = b; stride = s; vl = VL_W'(n); sew = 2'(w);
    @(negedge clk);
    start = 1'b0;
    k = 0; wt = 0; cycles = 0;
    d = $urandom_range(0, max_wait);
    while (!done && cycles < 600) begin
      dbus_ack = 1'b0;
      chk("busy_active", busy, 1'b1);
      chk("cyc_in_req", dbus_cyc, 1'b1);
      if (dbus_cyc) begin
        chk("elem_idx", elem_idx, k);
        if (k < exp_adr.size()) begin
          chk("adr", dbus_adr, exp_adr[k]);
          chk("sel", dbus_sel, exp_sel[k]);
          chk("we", dbus_we, w_e);
        end else begin
          chk("extra_elem", k, exp_adr.size());
        end
        if (wt == d) begin
          dbus_ack = 1'b1;
          k++;
          wt = 0;
          d = $urandom_range(0, max_wait);
        end else begin
          wt++;
        end
      end
      if (poke_start) begin
        start = ($urandom_range(0, 2) == 0);
        base  = $urandom;
        vl    = VL_W'($urandom_range(0, 7));
        sew   = 2'($urandom_range(0, 3));
        we    = ~w_e;
      end
      @(negedge clk);
      cycles++;
    end
    dbus_ack = 1'b0;
    start = 1'b0;
    chk("timeout", (cycles < 600), 1'b1);
    chk("done", done, 1'b1);
    chk("err", err, exp_err);
    chk("elem_count", k, exp_adr.size());
    if (exp_adr.size() == 0) chk("fast_done_latency", cycles, 0);
    @(negedge clk);
    chk("done_pulse_end", done, 1'b0);
    chk("idle_busy", busy, 1'b0);
    chk("idle_cyc", dbus_cyc, 1'b0);
  endtask

  initial begin
    #1;
    chk("rst_cyc", dbus_cyc, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_err", err, 1'b0);
    chk("rst_adr", dbus_adr, 32'h0);
    chk("rst_sel", dbus_sel, 4'h0);
    chk("rst_we", dbus_we, 1'b0);
    chk("rst_idx", elem_idx, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    run_op(1'b1, 32'h0000_1000, 32'd4, 4, 2, 0, 1'b0);
    run_op(1'b0, 32'h0000_2001, 32'd1, 3, 0, 0, 1'b0);
    run_op(1'b0, 32'h0000_3000, 32'hFFFF_FFF0, 2, 2, 0, 1'b0);
    run_op(1'b0, 32'h0000_4002, 32'd4, 2, 2, 0, 1'b0);
    run_op(1'b1, 32'h0000_4000, 32'd4, 2, 3, 0, 1'b0);
    run_op(1'b1, 32'h0000_4000, 32'd4, 0, 2, 0, 1'b0);
    run_op(1'b1, 32'h0000_5003, 32'd2, 2, 1, 0, 1'b0);
    run_op(1'b0, 32'hFFFF_FFFE, 32'd2, 3, 1, 0, 1'b0);
    run_op(1'b1, 32'h0000_6000, 32'd4, 4, 2, 3, 1'b1);

    // Reset mid-transfer after two acks, then restart at a fresh base.
    @(negedge clk);
    start = 1'b1; we = 1'b1; base = 32'h0000_7000; stride = 32'd4; vl = VL_W'(4); sew = 2'd2;
    @(negedge clk);
    start = 1'b0;
    dbus_ack = 1'b1;
    @(negedge clk);
    @(negedge clk);
    dbus_ack = 1'b0;
    chk("pre_rst_idx", elem_idx, 2);
    chk("pre_rst_cyc", dbus_cyc, 1'b1);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_cyc", dbus_cyc, 1'b0);
    chk("mid_rst_busy", busy, 1'b0);
    chk("mid_rst_adr", dbus_adr, 32'h0);
    chk("mid_rst_sel", dbus_sel, 4'h0);
    chk("mid_rst_we", dbus_we, 1'b0);
    chk("mid_rst_idx", elem_idx, 0);
    chk("mid_rst_done", done, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    run_op(1'b0, 32'h0000_8000, 32'd4, 4, 2, 1, 1'b0);

    for (int t = 0; t < 50; t++) begin
      logic [31:0] rb;
      logic [31:0] rs;
      int rw;
      rb = $urandom;
      rw = $urandom_range(0, 3);
      if ($urandom_range(0, 3) != 0) rb[1:0] = (rw == 2) ? 2'b00 : ((rw == 1) ? {rb[1], 1'b0} : rb[1:0]);
      case ($urandom_range(0, 4))
        0:       rs = 32'd0;
        1:       rs = 32'(1 << (rw % 3));
        2:       rs = -32'(1 << (rw % 3));
        3:       rs = $urandom_range(0, 40);
        default: rs = $urandom;
      endcase
      run_op(1'($urandom), rb, rs, $urandom_range(0, 9), rw, $urandom_range(0, 3), 1'($urandom));
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/serv_vlsu_agu.md
SERV_VLSU_AGU -- requirements
Module: serv_vlsu_agu

Interface
REQ-001 SHALL have parameter VL_W, default 6: width of the vector-length/element-count fields (max 2^VL_W-1 elements).
REQ-002 SHALL have one clock and an asynchronous, active-low reset: i_clk  input  1  clock, all state on rising edge.
REQ-003 SHALL have port i_rst_n  input  1  asynchronous active-low reset.
REQ-004 SHALL have port i_start  input  1  one-cycle pulse starting a vector memory operation; sampled only in IDLE.
REQ-005 SHALL have port i_we  input  1  1=vector store, 0=vector load; latched on accepted start.
REQ-006 SHALL have port i_base  input  32  scalar base address (rs1 value from buffer register); latched on start.
REQ-007 SHALL have port i_stride  input  32  byte stride (rs2 value); latched on start.
REQ-008 SHALL have port i_vl  input  VL_W  element count; latched on start.
REQ-009 SHALL have port i_sew  input  2  element width: 00=8b, 01=16b, 10=32b, 11=reserved.
REQ-010 SHALL have ports o_dbus_adr (output, 32, word-aligned address), o_dbus_sel (output, 4, byte lanes), o_dbus_we (output, 1), o_dbus_cyc (output, 1), i_dbus_ack (input, 1).
REQ-011 SHALL have ports o_elem_idx (output, VL_W, index of element in flight), o_busy (output, 1), o_done (output, 1, one-cycle completion pulse), o_err (output, 1, valid with o_done: misaligned/reserved abort).

Function
REQ-012 SHALL implement FSM IDLE -> REQ -> DONE -> IDLE; o_busy=1 in REQ and DONE.
REQ-013 IDLE + i_start: latch inputs, set idx=0, addr=i_base; go REQ if i_vl!=0 and i_sew!=11, else DONE; i_start in REQ/DONE SHALL be ignored.
REQ-014 In REQ, o_dbus_cyc=1, o_dbus_adr={addr[31:2],2'b00}, o_dbus_we=latched i_we, stable until i_dbus_ack.
REQ-015 o_dbus_sel: sew 8b -> 0001<<addr[1:0]; 16b -> 0011<<addr[1:0]; 32b -> 1111.
REQ-016 Element misaligned (16b with addr[0]=1; 32b with addr[1:0]!=0) SHALL be detected before issue: cyc stays 0, go DONE with o_err=1.
REQ-017 On ack in REQ: addr <= addr+stride (32-bit wraparound, no error), idx <= idx+1; if idx==vl-1 go DONE.
REQ-018 DONE SHALL last exactly one cycle: o_done=1, o_err as determined, then IDLE.
REQ-019 i_dbus_ack outside REQ SHALL be ignored; one element per ack, minimum one cycle per element.
REQ-020 sew=11 or vl=0 SHALL yield DONE next cycle with o_err = (sew==11), no bus cycle.

Reset
REQ-021 Asserting i_rst_n low at any time, including mid-transfer, SHALL immediately force IDLE, o_dbus_cyc=0, o_done=0, o_err=0, o_busy=0, o_dbus_we=0, o_dbus_sel=0, o_dbus_adr=0, o_elem_idx=0.
REQ-022 After deassertion the first accepted i_start SHALL behave as from a clean IDLE; an aborted transfer SHALL not resume.

Configuration
REQ-023 Macro SERV_VLSU_STRIDE_EN defined: address increment = latched i_stride (any value, incl. 0 and negative).
REQ-024 SERV_VLSU_STRIDE_EN undefined: i_stride ignored, no stride register; increment = element size (1, 2 or 4 bytes), unit-stride only.

Verification
REQ-025 Unit store: base=0x1000, sew=10, vl=4, stride=4, ack each cycle -> adr 0x1000,0x1004,0x1008,0x100C, sel=1111, we=1, o_done pulse after 4th ack, o_err=0.
REQ-026 Byte load: base=0x2001, sew=00, vl=3, stride=1 -> adr 0x2000,0x2000,0x2000, sel 0010,0100,1000, we=0.
REQ-027 Strided (macro on): base=0x3000, stride=0xFFFFFFF0, sew=10, vl=2 -> adr 0x3000 then 0x2FF0; macro off -> 0x3000 then 0x3004.
REQ-028 Misalign: base=0x4002, sew=10, vl=2 -> no cyc, o_done=1 & o_err=1 one cycle after start; sew=11 -> same; vl=0 -> o_done with o_err=0.
REQ-029 Backpressure/reset: vl=4, ack delayed 3 cycles per element -> adr/sel/we stable while waiting; i_start during REQ ignored; i_rst_n low after 2nd ack -> cyc=0 immediately, next start restarts idx=0 at new base.
